// File: rtl/sdc_pkg.sv
// Shared constants and types for the SD card DAT0 data path.
package sdc_pkg;

   localparam logic [15:0] CRC16_POLY      = 16'h1021;
   localparam int unsigned SDC_BLOCK_BYTES = 512;

   typedef enum logic [2:0] {
      StIdle,
      StWaitStart,
      StData,
      StCrc,
      StEndBit,
      StDone
   } sdc_rx_state_e;

endpackage

// File: rtl/sdc_crc16_serial.sv
// Bit-serial CRC-16-CCITT (x^16+x^12+x^5+1), init 0, no final XOR; clear wins over en.
module sdc_crc16_serial
   import sdc_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = crc_q[15] ^ din_i;
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/sdc_reader_data_rx.sv
// DAT0 block receiver: start-bit hunt, MSB-first byte deserialiser, CRC16 and end-bit check.
module sdc_reader_data_rx
   import sdc_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES   = SDC_BLOCK_BYTES,
   parameter int unsigned START_TIMEOUT = 65535,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       bit_en_i,
   input  logic       dat_in_i,
   input  logic       arm_i,
   output logic [7:0] byte_out_o,
   output logic       byte_valid_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       crc_ok_o,
   output logic       crc_err_o,
   output logic       frame_err_o,
   output logic       timeout_o
);

   localparam int unsigned   NumBits = 8 * BLOCK_BYTES;
   localparam logic [CNT_W-1:0] LastBit    = CNT_W'(NumBits - 1);
   localparam logic [CNT_W-1:0] LastCrcBit = CNT_W'(15);
   localparam logic [CNT_W-1:0] TmoMax     = CNT_W'(START_TIMEOUT);

   if (64'(NumBits) > (64'd1 << CNT_W)) begin : g_bad_block_size
      $error("8*BLOCK_BYTES does not fit the CNT_W-bit bit counter");
   end
   if (START_TIMEOUT < 1 || 64'(START_TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
      $error("START_TIMEOUT must be in 1 .. 2**CNT_W-1");
   end

   sdc_rx_state_e    state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [6:0]       shift_q, shift_d;
   logic [15:0]      rx_crc_q, rx_crc_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic             crc_ok_q, crc_ok_d;
   logic             crc_err_q, crc_err_d;
   logic             frame_err_q, frame_err_d;
   logic             timeout_q, timeout_d;
   logic [15:0]      crc_calc;
   logic             crc_clear, crc_en;

   // Generator restarts on the start bit and only advances on data bits.
   assign crc_clear = (state_q == StWaitStart) && bit_en_i && !dat_in_i;
   assign crc_en    = (state_q == StData) && bit_en_i;

   sdc_crc16_serial u_crc (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (crc_clear),
      .en_i    (crc_en),
      .din_i   (dat_in_i),
      .crc_o   (crc_calc)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      shift_d      = shift_q;
      rx_crc_d     = rx_crc_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      crc_err_d    = crc_err_q;
      frame_err_d  = frame_err_q;
      timeout_d    = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (arm_i) begin
               state_d     = StWaitStart;
               tmo_cnt_d   = '0;
               crc_ok_d    = 1'b0;
               crc_err_d   = 1'b0;
               frame_err_d = 1'b0;
               timeout_d   = 1'b0;
            end
         end
         StWaitStart: begin
            if (bit_en_i) begin
               if (!dat_in_i) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end else if (tmo_cnt_q >= TmoMax - CNT_W'(1)) begin
                  tmo_cnt_d = TmoMax;
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
               end
            end
         end
         StData: begin
            if (bit_en_i) begin
               shift_d   = {shift_q[5:0], dat_in_i};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q[2:0] == 3'd7) begin
                  byte_d       = {shift_q, dat_in_i};
                  byte_valid_d = 1'b1;
               end
               if (bit_cnt_q == LastBit) begin
                  state_d   = StCrc;
                  bit_cnt_d = '0;
               end
            end
         end
         StCrc: begin
            if (bit_en_i) begin
               rx_crc_d  = {rx_crc_q[14:0], dat_in_i};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LastCrcBit) begin
                  state_d = StEndBit;
               end
            end
         end
         StEndBit: begin
            if (bit_en_i) begin
               frame_err_d = ~dat_in_i;
               crc_err_d   = (rx_crc_q != crc_calc);
               crc_ok_d    = dat_in_i && (rx_crc_q == crc_calc);
               state_d     = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         bit_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         shift_q      <= '0;
         rx_crc_q     <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         crc_err_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         shift_q      <= shift_d;
         rx_crc_q     <= rx_crc_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         crc_ok_q     <= crc_ok_d;
         crc_err_q    <= crc_err_d;
         frame_err_q  <= frame_err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign byte_out_o   = byte_q;
   assign byte_valid_o = byte_valid_q;
   assign busy_o       = (state_q == StWaitStart) || (state_q == StData) ||
                         (state_q == StCrc) || (state_q == StEndBit);
   assign done_o       = (state_q == StDone);
   assign crc_ok_o     = crc_ok_q;
   assign crc_err_o    = crc_err_q;
   assign frame_err_o  = frame_err_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sdc_reader_data_rx.sv
// Directed bench for sdc_reader_data_rx: good/bad CRC, framing, timeout and reset mid-block.
module tb_sdc_reader_data_rx;

   logic       clk = 1'b0;
   logic       reset_i, bit_en_i, dat_in_i, arm_i;
   logic [7:0] byte_out_o;
   logic       byte_valid_o, busy_o, done_o, crc_ok_o, crc_err_o, frame_err_o, timeout_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor-owned counters; the stimulus only snapshots them.
   int         byte_cnt = 0, byte_bad = 0, lat_bad = 0, done_cnt = 0;
   logic [3:0] cap_flags = 4'h0;
   logic       strobe_prev = 1'b0;
   logic [7:0] exp_byte = 8'h00;

   sdc_reader_data_rx #(
      .BLOCK_BYTES   (512),
      .START_TIMEOUT (100),
      .CNT_W         (16)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .bit_en_i     (bit_en_i),
      .dat_in_i     (dat_in_i),
      .arm_i        (arm_i),
      .byte_out_o   (byte_out_o),
      .byte_valid_o (byte_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .crc_ok_o     (crc_ok_o),
      .crc_err_o    (crc_err_o),
      .frame_err_o  (frame_err_o),
      .timeout_o    (timeout_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) strobe_prev <= bit_en_i;

   always @(negedge clk) begin
      if (byte_valid_o) begin
         byte_cnt = byte_cnt + 1;
         if (byte_out_o != exp_byte) byte_bad = byte_bad + 1;
         if (!strobe_prev) lat_bad = lat_bad + 1;
      end
      if (done_o) begin
         done_cnt  = done_cnt + 1;
         cap_flags = {crc_ok_o, crc_err_o, frame_err_o, timeout_o};
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int period);
      dat_in_i = b;
      bit_en_i = 1'b1;
      tick();
      bit_en_i = 1'b0;
      dat_in_i = 1'b1;
      repeat (period - 1) tick();
   endtask

   task automatic pulse_arm();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
   endtask

   // Arm, idle-high preamble, start bit, uniform data, CRC, end bit.
   task automatic send_block(input logic [7:0] val, input logic [15:0] crc, input logic endb,
                             input int period, input bit arm_mid);
      pulse_arm();
      check_eq("busy_after_arm", 32'(busy_o), 32'd1);
      check_eq("flags_cleared_on_arm", 32'({crc_ok_o, crc_err_o, frame_err_o, timeout_o}), 32'd0);
      repeat (3) send_bit(1'b1, period);
      send_bit(1'b0, period);
      for (int i = 0; i < 512; i++) begin
         for (int b = 7; b >= 0; b--) send_bit(val[b], period);
         if (arm_mid && i == 100) pulse_arm();
      end
      for (int b = 15; b >= 0; b--) send_bit(crc[b], period);
      send_bit(endb, period);
   endtask

   task automatic finish_block(input string tag, input int b0, input int bb0, input int d0,
                               input logic [3:0] exp_flags);
      for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
      repeat (4) tick();
      check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      check_eq({tag, "_byte_count"}, 32'(byte_cnt - b0), 32'd512);
      check_eq({tag, "_byte_value_errs"}, 32'(byte_bad - bb0), 32'd0);
      check_eq({tag, "_flags_ok_cerr_ferr_tmo"}, 32'(cap_flags), 32'(exp_flags));
      check_eq({tag, "_busy_dropped"}, 32'(busy_o), 32'd0);
      check_eq({tag, "_flags_held"}, 32'({crc_ok_o, crc_err_o, frame_err_o, timeout_o}),
               32'(exp_flags));
   endtask

   task automatic run_block(input string tag, input logic [7:0] val, input logic [15:0] crc,
                            input logic endb, input int period, input bit arm_mid,
                            input logic [3:0] exp_flags);
      int b0, bb0, d0;
      b0 = byte_cnt; bb0 = byte_bad; d0 = done_cnt;
      exp_byte = val;
      send_block(val, crc, endb, period, arm_mid);
      finish_block(tag, b0, bb0, d0, exp_flags);
   endtask

   initial begin
      int b0, d0;
      reset_i  = 1'b1;
      bit_en_i = 1'b0;
      dat_in_i = 1'b1;
      arm_i    = 1'b0;
      repeat (3) tick();
      check_eq("reset_outputs", 32'({byte_out_o, byte_valid_o, busy_o, done_o, crc_ok_o,
               crc_err_o, frame_err_o, timeout_o}), 32'd0);
      reset_i = 1'b0;
      tick();
      check_eq("idle_not_busy", 32'(busy_o), 32'd0);

      run_block("ff_every_clk", 8'hFF, 16'h7FA1, 1'b1, 1, 1'b0, 4'b1000);
      run_block("ff_every4_armbusy", 8'hFF, 16'h7FA1, 1'b1, 4, 1'b1, 4'b1000);
      run_block("zero_every4", 8'h00, 16'h0000, 1'b1, 4, 1'b0, 4'b1000);
      run_block("ff_bad_crc", 8'hFF, 16'h7FA0, 1'b1, 1, 1'b0, 4'b0100);
      run_block("ff_bad_end", 8'hFF, 16'h7FA1, 1'b0, 1, 1'b0, 4'b0010);

      // Start-bit timeout: 99 high strobes must not finish, the 100th must.
      b0 = byte_cnt; d0 = done_cnt;
      pulse_arm();
      for (int i = 0; i < 99; i++) send_bit(1'b1, 1);
      repeat (3) tick();
      check_eq("tmo_not_early", 32'(done_cnt - d0), 32'd0);
      check_eq("tmo_still_busy", 32'(busy_o), 32'd1);
      send_bit(1'b1, 1);
      repeat (3) tick();
      check_eq("tmo_done", 32'(done_cnt - d0), 32'd1);
      check_eq("tmo_flags", 32'(cap_flags), 32'b0001);
      check_eq("tmo_no_bytes", 32'(byte_cnt - b0), 32'd0);
      check_eq("tmo_busy_dropped", 32'(busy_o), 32'd0);

      // Reset after 37 bytes, then a clean block.
      b0 = byte_cnt; d0 = done_cnt;
      exp_byte = 8'hFF;
      pulse_arm();
      send_bit(1'b1, 1);
      send_bit(1'b0, 1);
      for (int i = 0; i < 37 * 8; i++) send_bit(1'b1, 1);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check_eq("rst_mid_outputs", 32'({byte_out_o, byte_valid_o, busy_o, done_o}), 32'd0);
      for (int i = 0; i < 40; i++) send_bit(1'b1, 1);
      repeat (10) tick();
      check_eq("rst_mid_bytes", 32'(byte_cnt - b0), 32'd37);
      check_eq("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      run_block("ff_after_reset", 8'hFF, 16'h7FA1, 1'b1, 1, 1'b0, 4'b1000);

      check_eq("byte_valid_latency", 32'(lat_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
